kmeans_pass_ctrl: RTL and testbench
===================================

KMEANS_PASS_CTRL -- requirements
Module: kmeans_pass_ctrl

Interface
REQ-001 Parameter DP_LAT, default 1, cycles from point issue to valid dp_cluster_addr (legal 1..4).
REQ-002 Parameter CNT_W, default 16, width of point count and per-cluster counts.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse beginning a pass; sampled only in IDLE.
REQ-006 num_points  in  CNT_W  points in the pass; captured on accepted start.
REQ-007 pt_valid  in  1  upstream point available.
REQ-008 pt_ready  out  1  controller accepts point this cycle.
REQ-009 pt_data  in  64  point, dims 1..4 at [15:0],[31:16],[47:32],[63:48], unsigned.
REQ-010 dp_point  out  64  point driven to distance datapath (combinational copy of pt_data).
REQ-011 dp_cluster_addr  in  2  nearest-cluster index from datapath (0..2).
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  one-cycle pulse at pass completion.
REQ-014 err  out  1  sticky: illegal cluster index (3) returned during pass.
REQ-015 cnt1, cnt2, cnt3  out  CNT_W each  points assigned per cluster.
REQ-016 sum_sel  in  4  selects accumulator {cluster 0..2, dim 0..3} as cluster*4+dim.
REQ-017 sum_data  out  32  combinational read of selected accumulator; sel 12..15 reads 0.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-019 IDLE->RUN on start with num_points>0; IDLE->DONE on start with num_points==0.
REQ-020 Accepted start clears all accumulators, counts, err, issued and in-flight counters.
REQ-021 pt_ready = 1 only in RUN while issued < num_points; transfer occurs when pt_valid && pt_ready.
REQ-022 Each transfer pushes tag and pt_data into a DP_LAT-deep valid/data delay line.
REQ-023 When delay-line tap valid: sample dp_cluster_addr; if 0..2 add each dim (zero-extended) to that cluster's 4 accumulators and increment its count; if 3 set err, no update.
REQ-024 RUN->DRAIN in the cycle the last point transfers; DRAIN->DONE when delay line empty.
REQ-025 DONE lasts one cycle asserting done, then IDLE; outputs hold until next accepted start.
REQ-026 start outside IDLE ignored; pt_valid without pt_ready has no effect.
REQ-027 Accumulators 32-bit, modulo 2^32 (65535 points x 65535 cannot overflow); counts cannot exceed num_points.
REQ-028 Delay line advances every cycle regardless of pt_valid (no backpressure to datapath).

Reset
REQ-029 reset has priority over all inputs and returns FSM to IDLE mid-pass, discarding in-flight points.
REQ-030 Reset values: pt_ready 0, busy 0, done 0, err 0, cnt1..3 0, all accumulators 0, delay line empty.

Configuration
REQ-031 Macro KMEANS_EMPTY_FLAG_EN defined: extra output empty_mask[2:0], bit k = (count of cluster k == 0), registered at DONE, reset 0.
REQ-032 Macro undefined: no empty_mask port or logic; all other behaviour identical.

Structure
REQ-033 Shared package kmeans_pkg holds state enum, NUM_CLUSTERS=3, NUM_DIMS=4, DIM_W=16, ACC_W=32.
REQ-034 Sub-module kmeans_acc_bank: one cluster's 4 accumulators plus count, with clear and add-enable; instantiated three times.

Verification
REQ-035 num_points=3, points (1,1,1,1),(2,2,2,2),(3,3,3,3), dp_cluster_addr 0,0,1 -> done once; cnt1=2,cnt2=1,cnt3=0; sum_sel 0 = 3, sum_sel 4 = 3.
REQ-036 start with num_points=0 -> done exactly 1 cycle later, busy never high, all counts 0.
REQ-037 pt_valid toggling 1,0,1,0 over 4 points, DP_LAT=3 -> all 4 accumulated, done after last tap drains.
REQ-038 dp_cluster_addr=3 on 2nd of 3 points -> err=1, that point not counted, cnt sum=2; err cleared by next start.
REQ-039 reset asserted mid-RUN after 2 of 5 points -> next cycle IDLE, all outputs 0, no done pulse.
REQ-040 65535 points of (65535,...) all to cluster 2 -> cnt3=65535, sum_sel 8 = 0xFFFE0001.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means pass controller and its accumulator banks.
package kmeans_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_CLUSTERS = 3;
  localparam int NUM_DIMS     = 4;
  localparam int DIM_W        = 16;
  localparam int ACC_W        = 32;

endpackage

// File: rtl/kmeans_acc_bank.sv
// One cluster's per-dimension 32-bit accumulators and its assigned-point count.
module kmeans_acc_bank
  import kmeans_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        add_en,
  input  logic [NUM_DIMS*DIM_W-1:0]   point,
  output logic [NUM_DIMS*ACC_W-1:0]   acc_flat,
  output logic [CNT_W-1:0]            count
);

  logic [CNT_W-1:0] count_reg;

  generate
    for (genvar gi = 0; gi < NUM_DIMS; gi++) begin : g_dim
      logic [ACC_W-1:0] acc_reg;

      always_ff @(posedge clk) begin
        if (reset || clear) begin
          acc_reg <= '0;
        end else if (add_en) begin
          acc_reg <= acc_reg + ACC_W'(point[gi*DIM_W +: DIM_W]);
        end
      end

      assign acc_flat[gi*ACC_W +: ACC_W] = acc_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (add_en) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/kmeans_pass_ctrl.sv
// K-means assignment-pass controller: issues points, tracks datapath latency, accumulates per cluster.
// Optional KMEANS_EMPTY_FLAG_EN adds empty_mask (clusters with no points, registered at DONE).
module kmeans_pass_ctrl
  import kmeans_pkg::*;
#(
  parameter int DP_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_points,
  input  logic             pt_valid,
  output logic             pt_ready,
  input  logic [63:0]      pt_data,
  output logic [63:0]      dp_point,
  input  logic [1:0]       dp_cluster_addr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  input  logic [3:0]       sum_sel,
`ifdef KMEANS_EMPTY_FLAG_EN
  output logic [2:0]       empty_mask,
`endif
  output logic [31:0]      sum_data
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] issued_reg;
  logic [CNT_W-1:0] num_points_reg;
  logic [2:0]       inflight_reg, inflight_next;
  logic             err_reg;
  logic [DP_LAT-1:0] valid_reg;
  logic [63:0]      data_reg [DP_LAT];

  logic             xfer;
  logic             start_acc;
  logic             tap_valid;
  logic [63:0]      tap_data;

  logic [NUM_DIMS*ACC_W-1:0] acc_flat [NUM_CLUSTERS];
  logic [CNT_W-1:0]          count_arr [NUM_CLUSTERS];
  logic [ACC_W-1:0]          acc_word [16];

  assign start_acc = (state_reg == IDLE) && start;
  assign pt_ready  = (state_reg == RUN) && (issued_reg < num_points_reg);
  assign xfer      = pt_valid && pt_ready;
  assign tap_valid = valid_reg[DP_LAT-1];
  assign tap_data  = data_reg[DP_LAT-1];
  assign dp_point  = pt_data;
  assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
  assign done      = (state_reg == DONE);
  assign err       = err_reg;

  assign inflight_next = inflight_reg + {2'b00, xfer} - {2'b00, tap_valid};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (num_points != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (xfer && (issued_reg + CNT_W'(1) == num_points_reg)) begin
          state_next = DRAIN;
        end
      end
      // Leave DRAIN on the edge that retires the last tap, so counts are final in DONE.
      DRAIN: begin
        if (inflight_next == 3'd0) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      issued_reg     <= '0;
      num_points_reg <= '0;
      inflight_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_acc) begin
        issued_reg     <= '0;
        num_points_reg <= num_points;
        inflight_reg   <= '0;
        err_reg        <= 1'b0;
      end else begin
        if (xfer) begin
          issued_reg <= issued_reg + CNT_W'(1);
        end
        inflight_reg <= inflight_next;
        if (tap_valid && (dp_cluster_addr == 2'd3)) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  // Fixed-latency delay line mirroring the distance datapath; never stalls.
  generate
    for (genvar gi = 0; gi < DP_LAT; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (reset || start_acc) begin
          valid_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          valid_reg[gi] <= xfer;
        end else begin
          valid_reg[gi] <= valid_reg[(gi == 0) ? 0 : gi-1];
        end
      end

      always_ff @(posedge clk) begin
        if (gi == 0) begin
          data_reg[gi] <= pt_data;
        end else begin
          data_reg[gi] <= data_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_CLUSTERS; gi++) begin : g_bank
      kmeans_acc_bank #(
        .CNT_W(CNT_W)
      ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_acc),
        .add_en  (tap_valid && (dp_cluster_addr == 2'(gi))),
        .point   (tap_data),
        .acc_flat(acc_flat[gi]),
        .count   (count_arr[gi])
      );
    end
  endgenerate

  assign cnt1 = count_arr[0];
  assign cnt2 = count_arr[1];
  assign cnt3 = count_arr[2];

  // Flatten to a 16-entry map so the unused selects 12..15 read as zero.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_word
      if (gi < NUM_CLUSTERS*NUM_DIMS) begin : g_acc
        assign acc_word[gi] = acc_flat[gi/NUM_DIMS][(gi%NUM_DIMS)*ACC_W +: ACC_W];
      end else begin : g_zero
        assign acc_word[gi] = '0;
      end
    end
  endgenerate

  assign sum_data = acc_word[sum_sel];

`ifdef KMEANS_EMPTY_FLAG_EN
  logic [2:0] empty_mask_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      empty_mask_reg <= '0;
    end else if (state_reg == DONE) begin
      empty_mask_reg <= {count_arr[2] == '0, count_arr[1] == '0, count_arr[0] == '0};
    end
  end

  assign empty_mask = empty_mask_reg;
`endif

endmodule

// File: tb/tb_kmeans_pass_ctrl.sv
// Directed self-checking bench for kmeans_pass_ctrl with a 3-cycle datapath model.
module tb_kmeans_pass_ctrl;

  localparam int LAT = 3;
  localparam int CW  = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] num_points;
  logic          pt_valid;
  logic          pt_ready;
  logic [63:0]   pt_data;
  logic [63:0]   dp_point;
  logic [1:0]    dp_cluster_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] cnt1, cnt2, cnt3;
  logic [3:0]    sum_sel;
  logic [31:0]   sum_data;
`ifdef KMEANS_EMPTY_FLAG_EN
  logic [2:0]    empty_mask;
`endif

  kmeans_pass_ctrl #(
    .DP_LAT(LAT),
    .CNT_W (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_points     (num_points),
    .pt_valid       (pt_valid),
    .pt_ready       (pt_ready),
    .pt_data        (pt_data),
    .dp_point       (dp_point),
    .dp_cluster_addr(dp_cluster_addr),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .cnt1           (cnt1),
    .cnt2           (cnt2),
    .cnt3           (cnt3),
    .sum_sel        (sum_sel),
`ifdef KMEANS_EMPTY_FLAG_EN
    .empty_mask     (empty_mask),
`endif
    .sum_data       (sum_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fails  = 0;
  int          done_cnt = 0;
  bit          busy_seen;
  bit          last_xfer;
  logic [1:0]  cur_addr;
  logic [1:0]  pipe_a [LAT];
  logic [63:0] pts [8];
  logic [1:0]  addrs [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: datapath model returns the cluster of each transferred point LAT cycles later.
  task automatic cycle();
    last_xfer = pt_valid && pt_ready;
    @(posedge clk);
    #1;
    for (int i = LAT-1; i > 0; i--) pipe_a[i] = pipe_a[i-1];
    pipe_a[0] = last_xfer ? cur_addr : 2'd0;
    dp_cluster_addr = pipe_a[LAT-1];
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_seen = 1'b1;
  endtask

  task automatic read_sum(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    sum_sel = sel;
    #1;
    check(tag, sum_data, exp);
  endtask

  task automatic run_pass(input int n, input bit toggle, input bit big, input int budget);
    int idx;
    int c;
    bit ph;
    idx = 0;
    c = 0;
    ph = 1'b1;
    done_cnt = 0;
    busy_seen = 1'b0;
    num_points = CW'(n);
    start = 1'b1;
    cycle();
    start = 1'b0;
    while (c < budget && done_cnt == 0) begin
      pt_valid = (idx < n) && (!toggle || ph);
      if (big) begin
        pt_data  = '1;
        cur_addr = 2'd2;
      end else if (idx < n && idx < 8) begin
        pt_data  = pts[idx];
        cur_addr = addrs[idx];
      end else begin
        pt_data  = '0;
        cur_addr = 2'd0;
      end
      ph = !ph;
      cycle();
      if (last_xfer) idx++;
      c++;
    end
    pt_valid = 1'b0;
    check("points_xfer", idx, n);
    check("done_seen", done_cnt, 1);
    repeat (3) cycle();
    check("done_once", done_cnt, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_points = '0;
    pt_valid = 1'b0;
    pt_data = '0;
    dp_cluster_addr = 2'd0;
    cur_addr = 2'd0;
    sum_sel = 4'd0;
    for (int i = 0; i < LAT; i++) pipe_a[i] = 2'd0;

    // Reset state
    repeat (2) cycle();
    check("rst_pt_ready", pt_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt1", cnt1, 0);
    read_sum("rst_sum0", 4'd0, 0);
    reset = 1'b0;
    cycle();

    // Three points, clusters 0,0,1
    pts[0] = 64'h0001_0001_0001_0001; addrs[0] = 2'd0;
    pts[1] = 64'h0002_0002_0002_0002; addrs[1] = 2'd0;
    pts[2] = 64'h0003_0003_0003_0003; addrs[2] = 2'd1;
    run_pass(3, 1'b0, 1'b0, 50);
    check("p1_busy_seen", busy_seen, 1);
    check("p1_cnt1", cnt1, 2);
    check("p1_cnt2", cnt2, 1);
    check("p1_cnt3", cnt3, 0);
    read_sum("p1_sum0", 4'd0, 3);
    read_sum("p1_sum4", 4'd4, 3);
    read_sum("p1_sum7", 4'd7, 3);
    read_sum("p1_sum12", 4'd12, 0);
    check("p1_err", err, 0);
    repeat (4) cycle();
    check("p1_hold_cnt1", cnt1, 2);
    read_sum("p1_hold_sum0", 4'd0, 3);

    // Zero-point pass
    done_cnt = 0;
    busy_seen = 1'b0;
    num_points = '0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    cycle();
    check("z_done_after", done, 0);
    check("z_busy_seen", busy_seen, 0);
    check("z_cnt1", cnt1, 0);
    check("z_cnt2", cnt2, 0);
    check("z_cnt3", cnt3, 0);

    // Four points with pt_valid toggling
    pts[0] = 64'h0004_0003_0002_0001; addrs[0] = 2'd0;
    pts[1] = 64'h0008_0007_0006_0005; addrs[1] = 2'd1;
    pts[2] = 64'h000C_000B_000A_0009; addrs[2] = 2'd2;
    pts[3] = 64'h0010_000F_000E_000D; addrs[3] = 2'd0;
    run_pass(4, 1'b1, 1'b0, 60);
    check("t_cnt1", cnt1, 2);
    check("t_cnt2", cnt2, 1);
    check("t_cnt3", cnt3, 1);
    read_sum("t_sum0", 4'd0, 14);
    read_sum("t_sum3", 4'd3, 20);
    read_sum("t_sum5", 4'd5, 6);
    read_sum("t_sum10", 4'd10, 11);

    // Illegal cluster index on the second point
    pts[0] = 64'h0001_0001_0001_0001; addrs[0] = 2'd0;
    pts[1] = 64'h0002_0002_0002_0002; addrs[1] = 2'd3;
    pts[2] = 64'h0003_0003_0003_0003; addrs[2] = 2'd1;
    run_pass(3, 1'b0, 1'b0, 50);
    check("e_err", err, 1);
    check("e_cnt_sum", 32'(cnt1) + 32'(cnt2) + 32'(cnt3), 2);
    read_sum("e_sum0", 4'd0, 1);
    read_sum("e_sum4", 4'd4, 3);
    run_pass(0, 1'b0, 1'b0, 10);
    check("e_err_clear", err, 0);

    // Start ignored mid-pass, then reset after two transfers
    done_cnt = 0;
    num_points = CW'(5);
    start = 1'b1;
    cycle();
    start = 1'b0;
    pt_valid = 1'b1;
    pt_data = pts[0];
    cur_addr = 2'd0;
    cycle();
    pt_data = pts[2];
    cycle();
    pt_valid = 1'b0;
    num_points = '0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("r_busy_pre", busy, 1);
    check("r_ready_pre", pt_ready, 1);
    reset = 1'b1;
    pt_valid = 1'b1;
    cycle();
    reset = 1'b0;
    pt_valid = 1'b0;
    check("r_busy", busy, 0);
    check("r_pt_ready", pt_ready, 0);
    check("r_done", done, 0);
    check("r_err", err, 0);
    check("r_cnt1", cnt1, 0);
    read_sum("r_sum0", 4'd0, 0);
    repeat (6) cycle();
    check("r_no_done", done_cnt, 0);
    check("r_cnt1_later", cnt1, 0);
    check("r_busy_later", busy, 0);

    // Maximum-size pass into cluster 2
    run_pass(65535, 1'b0, 1'b1, 70000);
    check("big_cnt3", cnt3, 65535);
    check("big_cnt1", cnt1, 0);
    read_sum("big_sum8", 4'd8, 32'hFFFE_0001);
    read_sum("big_sum11", 4'd11, 32'hFFFE_0001);
`ifdef KMEANS_EMPTY_FLAG_EN
    check("big_empty", empty_mask, 3'b011);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
